// File: rtl/shift_rotate_seq.sv
`default_nettype none
// ============================================================================
// Module      : shift_rotate_seq
// Description : Sequential 32-bit shifter/rotator. An accepted request loads
//               the operand into an accumulator and a 5-bit count, then the
//               accumulator is stepped once per RUN cycle until the count is
//               exhausted. The result is presented with a valid/ready
//               handshake and held until the consumer takes it.
//
// Ports       : clk        system clock (rising edge)
//               clr        synchronous active-high reset, highest priority
//               start      request; only accepted while in_ready=1
//               op         000 SHR, 001 SHRA, 010 SHL, 011 ROR, 100 ROL,
//                          101..111 pass-through
//               A          data operand
//               B          count; only B[4:0] is used (counts wrap mod 32)
//               in_ready   high in IDLE
//               busy       high in RUN
//               out_valid  high in DONE
//               out_ready  consumer accepts the result
//               result     accumulator contents
//
// Config      : SHIFT_ROTATE_SEQ_STEP4_EN - when defined, a RUN cycle moves
//               4 bit positions while the remaining count is >= 4, otherwise
//               1. Results are identical; only latency changes.
//
// Revision    : 1.0 - initial release
// ============================================================================
module shift_rotate_seq (
  input  logic        clk,
  input  logic        clr,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        in_ready,
  output logic        busy,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result
);

  // --------------------------------------------------------------------------
  // Operation encodings
  // --------------------------------------------------------------------------
  localparam logic [2:0] c_OP_SHR  = 3'b000;
  localparam logic [2:0] c_OP_SHRA = 3'b001;
  localparam logic [2:0] c_OP_SHL  = 3'b010;
  localparam logic [2:0] c_OP_ROR  = 3'b011;
  localparam logic [2:0] c_OP_ROL  = 3'b100;

  // --------------------------------------------------------------------------
  // State machine encoding
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [31:0] r_acc;
  logic [4:0]  r_cnt;
  logic [2:0]  r_opr;

  logic [31:0] w_step1;
  logic [31:0] w_acc_step;
  logic [4:0]  w_cnt_dec;
  logic [4:0]  w_cnt_next;
  logic        w_cnt_zero;
  logic        w_accept;

  // Upper count bits are architecturally ignored (counts wrap modulo 32).
  logic        w_unused_b;
  assign w_unused_b = ^B[31:5];

  // --------------------------------------------------------------------------
  // Single-position step
  // --------------------------------------------------------------------------
  always_comb begin
    w_step1 = r_acc;
    case (r_opr)
      c_OP_SHR:  w_step1 = {1'b0, r_acc[31:1]};
      c_OP_SHRA: w_step1 = {r_acc[31], r_acc[31:1]};
      c_OP_SHL:  w_step1 = {r_acc[30:0], 1'b0};
      c_OP_ROR:  w_step1 = {r_acc[0], r_acc[31:1]};
      c_OP_ROL:  w_step1 = {r_acc[30:0], r_acc[31]};
      default:   w_step1 = r_acc;
    endcase
  end

`ifdef SHIFT_ROTATE_SEQ_STEP4_EN
  // --------------------------------------------------------------------------
  // Four-position step, used only while at least four positions remain so the
  // tail of the count is always finished with single steps.
  // --------------------------------------------------------------------------
  logic [31:0] w_step4;
  logic        w_use4;

  always_comb begin
    w_step4 = r_acc;
    case (r_opr)
      c_OP_SHR:  w_step4 = {4'b0000, r_acc[31:4]};
      c_OP_SHRA: w_step4 = {{4{r_acc[31]}}, r_acc[31:4]};
      c_OP_SHL:  w_step4 = {r_acc[27:0], 4'b0000};
      c_OP_ROR:  w_step4 = {r_acc[3:0], r_acc[31:4]};
      c_OP_ROL:  w_step4 = {r_acc[27:0], r_acc[31:28]};
      default:   w_step4 = r_acc;
    endcase
  end

  assign w_use4     = (r_cnt >= 5'd4);
  assign w_acc_step = w_use4 ? w_step4 : w_step1;
  assign w_cnt_dec  = w_use4 ? 5'd4 : 5'd1;
`else
  assign w_acc_step = w_step1;
  assign w_cnt_dec  = 5'd1;
`endif

  // The step size never exceeds the remaining count, so this cannot wrap
  // while RUN holds a non-zero count.
  assign w_cnt_next = r_cnt - w_cnt_dec;
  assign w_cnt_zero = (r_cnt == 5'd0);
  assign w_accept   = (r_state == S_IDLE) && start;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and status outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    busy         = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (start) begin
          // A zero count has nothing to step: go straight to DONE.
          w_state_next = (B[4:0] != 5'd0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        // Leave RUN on the step that empties the count. The zero check only
        // protects against an unreachable empty-count RUN state.
        if (w_cnt_zero || (w_cnt_next == 5'd0)) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers: operands are captured only at acceptance so later
  // input changes cannot disturb an operation in flight.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (clr) begin
      r_acc <= 32'h0000_0000;
      r_cnt <= 5'd0;
      r_opr <= 3'b000;
    end else begin
      if (w_accept) begin
        r_acc <= A;
        r_cnt <= B[4:0];
        r_opr <= op;
      end else if ((r_state == S_RUN) && !w_cnt_zero) begin
        r_acc <= w_acc_step;
        r_cnt <= w_cnt_next;
      end
    end
  end

  assign result = r_acc;

endmodule
`default_nettype wire
